actuator_sequencer: RTL and testbench

Sequences the smart-home actuators so that at most one is driven at a time. Per-actuator request bits come from the sensor-decode FSM. The block grants the highest-priority request, holds each grant for a minimum on-time, and inserts a dead time after the heater or cooler releases. Buzzer grants are turned into a beep pattern. It sits between the state decoder and the actuator pins, and its `active` code feeds the same 3-bit display.

---
 rtl/smart_home_pkg.sv | 46 ++++
 rtl/actuator_sequencer_if.sv | 25 ++
 rtl/actuator_prio_enc.sv | 21 ++
 rtl/actuator_sequencer.sv | 129 ++++++++++++
 tb/tb_actuator_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/smart_home_pkg.sv
// Shared definitions for the smart-home actuator path: grant codes, request bit
// positions, sequencer states and the grant-to-pin drive mapping.
package smart_home_pkg;

    localparam int unsigned REQ_W = 6;
    localparam int unsigned ACT_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam int unsigned REQ_FDOOR  = 0;
    localparam int unsigned REQ_RDOOR  = 1;
    localparam int unsigned REQ_ALARM  = 2;
    localparam int unsigned REQ_WINDOW = 3;
    localparam int unsigned REQ_HEATER = 4;
    localparam int unsigned REQ_COOLER = 5;

    localparam logic [ACT_W-1:0] ACT_IDLE   = 3'd0;
    localparam logic [ACT_W-1:0] ACT_FDOOR  = 3'd1;
    localparam logic [ACT_W-1:0] ACT_RDOOR  = 3'd2;
    localparam logic [ACT_W-1:0] ACT_ALARM  = 3'd3;
    localparam logic [ACT_W-1:0] ACT_WINDOW = 3'd4;
    localparam logic [ACT_W-1:0] ACT_HEATER = 3'd5;
    localparam logic [ACT_W-1:0] ACT_COOLER = 3'd6;

    // DEAD is also a parameter name of the sequencer, so states carry a prefix
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_DEAD = 2'd2
    } seq_state_e;

    // Pin vector (request bit order) for a grant; buzzers follow the beep level
    function automatic logic [REQ_W-1:0] drive_vec(input logic [ACT_W-1:0] code,
                                                   input logic beep);
        drive_vec = '0;
        case (code)
            ACT_FDOOR:  drive_vec[REQ_FDOOR]  = 1'b1;
            ACT_RDOOR:  drive_vec[REQ_RDOOR]  = 1'b1;
            ACT_ALARM:  drive_vec[REQ_ALARM]  = beep;
            ACT_WINDOW: drive_vec[REQ_WINDOW] = beep;
            ACT_HEATER: drive_vec[REQ_HEATER] = 1'b1;
            ACT_COOLER: drive_vec[REQ_COOLER] = 1'b1;
            default:    drive_vec = '0;
        endcase
    endfunction

endpackage

// File: rtl/actuator_sequencer_if.sv
// Request/drive bundle between the sensor-decode FSM, the sequencer and the pins.
interface actuator_sequencer_if;
    import smart_home_pkg::*;

    logic [REQ_W-1:0] req;
    logic             fdoor;
    logic             rdoor;
    logic             winbuzz;
    logic             alarmbuzz;
    logic             heater;
    logic             cooler;
    logic [ACT_W-1:0] active;
    logic             busy;

    modport master (
        output req,
        input  fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, active, busy
    );

    modport slave (
        input  req,
        output fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, active, busy
    );

endinterface

// File: rtl/actuator_prio_enc.sv
// Fixed-priority request encoder: alarm > fdoor > rdoor > window > heater > cooler.
module actuator_prio_enc
    import smart_home_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    output logic             valid,
    output logic [ACT_W-1:0] code
);

    always_comb begin
        valid = |req;
        code  = ACT_IDLE;
        if (req[REQ_ALARM])       code = ACT_ALARM;
        else if (req[REQ_FDOOR])  code = ACT_FDOOR;
        else if (req[REQ_RDOOR])  code = ACT_RDOOR;
        else if (req[REQ_WINDOW]) code = ACT_WINDOW;
        else if (req[REQ_HEATER]) code = ACT_HEATER;
        else if (req[REQ_COOLER]) code = ACT_COOLER;
    end

endmodule

// File: rtl/actuator_sequencer.sv
// One-at-a-time actuator sequencer: priority grant, minimum on-time, dead time
// after heater/cooler, alarm preemption and buzzer beep generation.
module actuator_sequencer
    import smart_home_pkg::*;
#(
    parameter int unsigned MIN_ON    = 8,
    parameter int unsigned DEAD      = 4,
    parameter int unsigned BEEP_HALF = 2
) (
    input  logic                 clk,
    input  logic                 Rst,
    actuator_sequencer_if.slave  bus
);

    if (MIN_ON < 1 || MIN_ON > 255) begin : g_bad_min_on
        $error("MIN_ON must be in 1..255");
    end
    if (DEAD < 1 || DEAD > 255) begin : g_bad_dead
        $error("DEAD must be in 1..255");
    end
    if (BEEP_HALF < 1 || BEEP_HALF > 255) begin : g_bad_beep_half
        $error("BEEP_HALF must be in 1..255");
    end

    localparam logic [CNT_W-1:0] MIN_ON_LD = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] BEEP_LD   = CNT_W'(BEEP_HALF - 1);

    logic             win_valid;
    logic [ACT_W-1:0] win_code;

    actuator_prio_enc u_prio_enc (
        .req   (bus.req),
        .valid (win_valid),
        .code  (win_code)
    );

    seq_state_e       state_q;
    logic [ACT_W-1:0] code_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] beep_cnt_q;
    logic             beep_q;
    logic [REQ_W-1:0] drv_q;
    logic             busy_q;

    logic             take_c;
    logic             to_dead_c;
    logic             to_idle_c;
    logic             beep_nx_c;
    logic [REQ_W-1:0] hold_drv_c;

    // Transition decision; a new grant always goes to the current priority winner
    always_comb begin
        take_c    = 1'b0;
        to_dead_c = 1'b0;
        to_idle_c = 1'b0;
        case (state_q)
            ST_IDLE: take_c = win_valid;
            ST_ON: begin
                if (bus.req[REQ_ALARM] && code_q != ACT_ALARM) begin
                    take_c = 1'b1;
                end else if (cnt_q == '0 && (!win_valid || win_code != code_q)) begin
                    if (code_q == ACT_HEATER || code_q == ACT_COOLER) to_dead_c = 1'b1;
                    else if (win_valid)                               take_c    = 1'b1;
                    else                                              to_idle_c = 1'b1;
                end
            end
            ST_DEAD: begin
                if (bus.req[REQ_ALARM] || cnt_q == '0) begin
                    if (win_valid) take_c    = 1'b1;
                    else           to_idle_c = 1'b1;
                end
            end
            default: to_idle_c = 1'b1;
        endcase
    end

    assign beep_nx_c  = (beep_cnt_q == '0) ? ~beep_q : beep_q;
    assign hold_drv_c = drive_vec(code_q, beep_nx_c);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            code_q     <= ACT_IDLE;
            cnt_q      <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            drv_q      <= '0;
            busy_q     <= 1'b0;
        end else if (take_c) begin
            state_q    <= ST_ON;
            code_q     <= win_code;
            cnt_q      <= MIN_ON_LD;
            beep_cnt_q <= BEEP_LD;
            beep_q     <= 1'b1;
            drv_q      <= drive_vec(win_code, 1'b1);
            busy_q     <= 1'b1;
        end else if (to_dead_c) begin
            state_q    <= ST_DEAD;
            code_q     <= ACT_IDLE;
            cnt_q      <= DEAD_LD;
            drv_q      <= '0;
            busy_q     <= 1'b1;
        end else if (to_idle_c) begin
            state_q    <= ST_IDLE;
            code_q     <= ACT_IDLE;
            cnt_q      <= '0;
            drv_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == ST_ON) begin
                beep_q     <= beep_nx_c;
                beep_cnt_q <= (beep_cnt_q == '0) ? BEEP_LD : beep_cnt_q - CNT_W'(1);
                drv_q      <= hold_drv_c;
            end
        end
    end

    assign bus.fdoor     = drv_q[REQ_FDOOR];
    assign bus.rdoor     = drv_q[REQ_RDOOR];
    assign bus.alarmbuzz = drv_q[REQ_ALARM];
    assign bus.winbuzz   = drv_q[REQ_WINDOW];
    assign bus.heater    = drv_q[REQ_HEATER];
    assign bus.cooler    = drv_q[REQ_COOLER];
    assign bus.active    = code_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_actuator_sequencer.sv
// Self-checking bench for actuator_sequencer: reference model of grant age and
// dead time, a directed vector table, hand-written corner sequences and random traffic.
module tb_actuator_sequencer;

    localparam int MIN_ON    = 8;
    localparam int DEAD      = 4;
    localparam int BEEP_HALF = 2;

    logic clk;
    logic Rst;

    actuator_sequencer_if bus ();

    actuator_sequencer #(
        .MIN_ON    (MIN_ON),
        .DEAD      (DEAD),
        .BEEP_HALF (BEEP_HALF)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // Model: granted request index (-1 none), cycles since grant, dead cycles left
    int m_grant;
    int m_age;
    int m_dead;

    typedef struct {
        logic [5:0] req;
        logic [2:0] active;
        logic [5:0] drv;
    } vec_t;

    vec_t tbl[10];

    function automatic int winner(input logic [5:0] r);
        if (r[2]) return 2;
        if (r[0]) return 0;
        if (r[1]) return 1;
        if (r[3]) return 3;
        if (r[4]) return 4;
        if (r[5]) return 5;
        return -1;
    endfunction

    function automatic logic [9:0] model_out();
        logic [5:0] d;
        logic [2:0] a;
        logic       b;
        d = '0;
        a = 3'd0;
        b = (m_grant >= 0) || (m_dead > 0);
        if (m_grant >= 0) begin
            if (m_grant == 2 || m_grant == 3) d[m_grant] = ((m_age / BEEP_HALF) % 2) == 0;
            else                              d[m_grant] = 1'b1;
            case (m_grant)
                0: a = 3'd1;
                1: a = 3'd2;
                2: a = 3'd3;
                3: a = 3'd4;
                4: a = 3'd5;
                default: a = 3'd6;
            endcase
        end
        return {b, a, d};
    endfunction

    task automatic model_reset();
        m_grant = -1;
        m_age   = 0;
        m_dead  = 0;
    endtask

    task automatic model_step(input logic [5:0] r);
        int w;
        w = winner(r);
        if (m_grant >= 0) begin
            if (r[2] && m_grant != 2) begin
                m_grant = 2;
                m_age   = 0;
            end else if (m_age >= MIN_ON - 1 && w != m_grant) begin
                if (m_grant >= 4) begin
                    m_grant = -1;
                    m_dead  = DEAD;
                end else begin
                    m_grant = w;
                end
                m_age = 0;
            end else begin
                m_age++;
            end
        end else if (m_dead > 0) begin
            if (r[2] || m_dead == 1) begin
                m_dead  = 0;
                m_grant = w;
                m_age   = 0;
            end else begin
                m_dead--;
            end
        end else begin
            m_grant = w;
            m_age   = 0;
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {bus.busy, bus.active, bus.cooler, bus.heater, bus.winbuzz,
                bus.alarmbuzz, bus.rdoor, bus.fdoor};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Apply one request vector across one clock edge and compare with the model
    task automatic step(input logic [5:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check("model", 16'(dut_out()), 16'(model_out()));
    endtask

    task automatic do_reset();
        bus.req = '0;
        Rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        Rst = 1'b0;
        check("reset_state", 16'(dut_out()), 16'd0);
    endtask

    initial begin
        logic [0:11] wpat;
        int lows;
        logic seen;

        n_vec = 0;
        n_bad = 0;
        bus.req = '0;
        Rst = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            tbl[i].req    = (i < 3) ? 6'b000001 : 6'b000000;
            tbl[i].active = (i < 8) ? 3'b001 : 3'b000;
            tbl[i].drv    = (i < 8) ? 6'b000001 : 6'b000000;
        end

        // Single fdoor request: 8-cycle grant, then back to idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].req);
            check("tbl_active", 16'(bus.active), 16'(tbl[i].active));
            check("tbl_drive", 16'(dut_out() & 10'h03f), 16'(tbl[i].drv));
        end

        // Priority, then heater release with dead time before cooler
        do_reset();
        step(6'b110010);
        check("prio_rdoor", 16'(bus.active), 16'd2);
        repeat (9) step(6'b110010);
        step(6'b110000);
        check("prio_heater", 16'({bus.active, bus.heater, bus.rdoor}), 16'b101_1_0);
        repeat (8) step(6'b110000);
        step(6'b100000);
        lows = 0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.cooler) begin
                seen = 1'b1;
                break;
            end
            if (dut_out() == 10'h200) lows++;
            step(6'b100000);
        end
        check("dead_then_cooler", 16'(seen), 16'd1);
        check("dead_low_cycles", 16'(lows), 16'(DEAD));

        // Alarm preempts heater early in its grant, no dead gap
        do_reset();
        step(6'b010000);
        step(6'b010000);
        check("pre_heater_on", 16'(bus.heater), 16'd1);
        step(6'b010100);
        check("preempt", 16'({bus.active, bus.alarmbuzz, bus.heater}), 16'b011_1_0);

        // Window beep pattern, then phase restart after regrant
        do_reset();
        wpat = 12'b110011001100;
        for (int i = 0; i < 12; i++) begin
            step(6'b001000);
            check("beep_pattern", 16'(bus.winbuzz), 16'(wpat[i]));
        end
        step(6'b000000);
        check("beep_release", 16'(bus.active), 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(6'b001000);
            check("beep_regrant", 16'(bus.winbuzz), 16'(wpat[i]));
        end

        // Asynchronous reset mid cooler grant
        do_reset();
        repeat (3) step(6'b100000);
        check("cooler_on", 16'(bus.cooler), 16'd1);
        #2;
        Rst = 1'b1;
        #1;
        check("async_reset", 16'(dut_out()), 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        bus.req = '0;
        Rst = 1'b0;
        repeat (3) step(6'b000000);
        check("idle_after_reset", 16'({bus.busy, bus.active}), 16'd0);

        // Alarm raised in the second dead cycle
        do_reset();
        repeat (8) step(6'b010000);
        step(6'b000000);
        check("dead_entry", 16'(dut_out()), 16'h200);
        step(6'b000000);
        step(6'b000100);
        check("alarm_in_dead", 16'({bus.active, bus.alarmbuzz}), 16'b011_1);

        // Random traffic, alarm kept rare so long grants still happen
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [5:0] r;
            r = 6'($urandom) & 6'($urandom);
            if (($urandom % 6) != 0) r[2] = 1'b0;
            if (($urandom % 10) == 0) r = '0;
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
